layer_sched: RTL and testbench

- Top-level layer sequencer and DRAM port arbiter for the LeNet inference engine.
- Launches the layer engines (conv1, pool1, conv2, pool2, full_conn by default) one at a time, in index order.
- Routes the single DRAM port to whichever engine is active, and guards each layer with a watchdog.
- Reports run status and cycle counts to the host.

---
 rtl/layer_sched.sv | 182 ++++++++++++++++++
 tb/tb_layer_sched.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sched.sv
// layer_sched: launches the LeNet layer engines one at a time in index order,
// steers the shared DRAM port to the active engine and watchdogs every layer.
module layer_sched #(
    parameter int NUM_LAYERS = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 18,
    parameter int TIMEOUT    = 1048576,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             start,
    input  logic                             abort,
    output logic                             busy,
    output logic                             done,
    output logic                             err,
    output logic [2:0]                       err_layer,
    output logic [CNT_WIDTH-1:0]             total_cycles,
    output logic [NUM_LAYERS-1:0]            layer_en,
    input  logic [NUM_LAYERS-1:0]            layer_done,
    output logic [NUM_LAYERS-1:0]            layer_flush,
    output logic [NUM_LAYERS-1:0]            layer_valid,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_addr_in,
    input  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_addr_out,
    input  logic [NUM_LAYERS*DATA_WIDTH-1:0] layer_data_out,
    input  logic [NUM_LAYERS-1:0]            layer_en_rd,
    input  logic [NUM_LAYERS-1:0]            layer_en_wr,
    input  logic                             dram_valid,
    output logic [ADDR_WIDTH-1:0]            addr_in,
    output logic [ADDR_WIDTH-1:0]            addr_out,
    output logic [DATA_WIDTH-1:0]            data_out,
    output logic                             dram_en_rd,
    output logic                             dram_en_wr
);
    localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NUM_LAYERS - 1);
    localparam logic [CNT_WIDTH-1:0] RUN_LIMIT = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  run_cnt_q, run_cnt_d;
    logic [CNT_WIDTH-1:0]  total_q, total_d;
    logic [2:0]            err_layer_q, err_layer_d;
    logic                  flush_q, flush_d;
    logic                  busy_q, done_q, err_q;
    logic [NUM_LAYERS-1:0] layer_en_q;
    logic                  active_s;
    int                    sel_s;

    // Next-state logic for the sequencer, counters and error capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_cnt_d   = run_cnt_q;
        total_d     = total_q;
        err_layer_d = err_layer_q;
        flush_d     = 1'b0;
        if ((state_q == S_LAUNCH) || (state_q == S_RUN)) begin
            total_d = (total_q == CNT_MAX) ? total_q : total_q + CNT_WIDTH'(1);
        end else begin
            total_d = total_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LAUNCH;
                    idx_d       = '0;
                    total_d     = '0;
                    err_layer_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // A done pulse in the watchdog's last cycle still counts as success.
                if (layer_done[idx_q]) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_LAUNCH;
                    end
                end else if (run_cnt_q == RUN_LIMIT) begin
                    state_d     = S_ERR;
                    err_layer_d = 3'(idx_q);
                end else begin
                    run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start || abort) begin
                    state_d = S_IDLE;
                    flush_d = 1'b1;
                end else begin
                    state_d = S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            flush_d = 1'b1;
        end else begin
            flush_d = flush_d;
        end
    end

    // State, counters and registered status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            run_cnt_q   <= '0;
            total_q     <= '0;
            err_layer_q <= 3'd0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            layer_en_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_cnt_q   <= run_cnt_d;
            total_q     <= total_d;
            err_layer_q <= err_layer_d;
            flush_q     <= flush_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FINISH);
            err_q       <= (state_d == S_ERR);
            layer_en_q  <= (state_d == S_LAUNCH) ? (NUM_LAYERS'(1) << idx_d) : '0;
        end
    end

    assign active_s = (state_q == S_LAUNCH) || (state_q == S_RUN);
    assign sel_s    = int'(idx_q);

    // DRAM port steering: zero-latency mux onto the active engine's slice.
    always_comb begin
        if (active_s) begin
            addr_in     = layer_addr_in[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
            addr_out    = layer_addr_out[sel_s*ADDR_WIDTH +: ADDR_WIDTH];
            data_out    = layer_data_out[sel_s*DATA_WIDTH +: DATA_WIDTH];
            dram_en_rd  = layer_en_rd[idx_q];
            dram_en_wr  = layer_en_wr[idx_q];
            layer_valid = NUM_LAYERS'(dram_valid) << idx_q;
        end else begin
            addr_in     = '0;
            addr_out    = '0;
            data_out    = '0;
            dram_en_rd  = 1'b0;
            dram_en_wr  = 1'b0;
            layer_valid = '0;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_layer    = err_layer_q;
    assign total_cycles = total_q;
    assign layer_en     = layer_en_q;
    assign layer_flush  = {NUM_LAYERS{flush_q}};

endmodule

// File: tb/tb_layer_sched.sv
// Testbench for layer_sched: stub engines, a cycle-level reference model,
// a table of whole-run scenarios, hand-written corner sequences and random traffic.
module tb_layer_sched;
    localparam int NL = 5;
    localparam int DW = 32;
    localparam int AW = 18;
    localparam int TO = 100;
    localparam int CW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst = 1'b0, start = 1'b0, abort = 1'b0;
    logic busy, done, err;
    logic [2:0] err_layer;
    logic [CW-1:0] total_cycles;
    logic [NL-1:0] layer_en, layer_flush, layer_valid;
    logic [NL-1:0] layer_done = '0, layer_en_rd = '0, layer_en_wr = '0;
    logic [NL*AW-1:0] layer_addr_in = '0, layer_addr_out = '0;
    logic [NL*DW-1:0] layer_data_out = '0;
    logic dram_valid = 1'b0;
    logic [AW-1:0] addr_in, addr_out;
    logic [DW-1:0] data_out;
    logic dram_en_rd, dram_en_wr;

    layer_sched #(.NUM_LAYERS(NL), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                  .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .srst(srst), .start(start), .abort(abort),
        .busy(busy), .done(done), .err(err), .err_layer(err_layer),
        .total_cycles(total_cycles), .layer_en(layer_en), .layer_done(layer_done),
        .layer_flush(layer_flush), .layer_valid(layer_valid),
        .layer_addr_in(layer_addr_in), .layer_addr_out(layer_addr_out),
        .layer_data_out(layer_data_out), .layer_en_rd(layer_en_rd),
        .layer_en_wr(layer_en_wr), .dram_valid(dram_valid),
        .addr_in(addr_in), .addr_out(addr_out), .data_out(data_out),
        .dram_en_rd(dram_en_rd), .dram_en_wr(dram_en_wr));

    int n_pass = 0, n_chk = 0;
    bit chk_en = 1'b0;

    // Stub engines and random-mode knobs
    int lat[NL];
    int cnt[NL];
    bit sp4 = 1'b0;
    bit rand_mode = 1'b0;
    int done_cnt = 0;

    // Reference model: phase 0 idle, 1 launch, 2 run, 3 finish, 4 error
    int m_ph = 0, m_k = 0, m_run = 0, m_errl = 0;
    longint m_tot = 0;
    bit m_fl = 1'b0;

    // Values sampled mid-cycle by tick
    logic s_busy, s_done, s_err;
    logic [NL-1:0] s_en, s_flush;
    logic [CW-1:0] s_total;
    logic [2:0] s_el;

    typedef struct {
        int l0, l1, l2, l3, l4;
        bit sp;
        int tot;
        int nd;
        bit e;
        int el;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic model_step();
        int old;
        bit fl;
        if (srst) begin
            m_ph = 0; m_k = 0; m_run = 0; m_tot = 0; m_errl = 0; m_fl = 1'b0;
            return;
        end
        old = m_ph;
        fl = 1'b0;
        if ((old == 1 || old == 2) && m_tot < 64'hFFFF_FFFF) m_tot++;
        case (old)
            0: if (start) begin m_ph = 1; m_k = 0; m_tot = 0; m_errl = 0; end
            1: begin m_run = 0; m_ph = 2; end
            2: begin
                m_run++;
                if (layer_done[m_k]) begin
                    if (m_k == NL - 1) m_ph = 3;
                    else begin m_k++; m_ph = 1; end
                end else if (m_run == TO) begin
                    m_ph = 4; m_errl = m_k;
                end
            end
            3: m_ph = 0;
            4: if (start || abort) begin m_ph = 0; fl = 1'b1; end
            default: m_ph = 0;
        endcase
        if (abort && old != 0) begin m_ph = 0; fl = 1'b1; end
        m_fl = fl;
    endtask

    task automatic tick(input bit s = 1'b0, input bit a = 1'b0, input bit r = 1'b0);
        logic [NL-1:0] d;
        logic [12:0] exp_ctl;
        logic [74:0] exp_dram;
        @(negedge clk);
        start = s; abort = a; srst = r;
        d = '0;
        for (int i = 0; i < NL; i++) begin
            if (layer_en[i]) begin
                if (rand_mode) lat[i] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 110));
                cnt[i] = lat[i];
            end else if (cnt[i] > 0) cnt[i]--;
            if (cnt[i] == 0) begin d[i] = 1'b1; cnt[i] = -1; end
            if (rand_mode && $urandom_range(0, 63) == 0) d[i] = 1'b1;
            layer_addr_in[i*AW +: AW]  = AW'($urandom);
            layer_addr_out[i*AW +: AW] = AW'($urandom);
            layer_data_out[i*DW +: DW] = $urandom;
        end
        if (sp4 && m_ph == 2 && m_k == 1) d[4] = 1'b1;
        layer_done  = d;
        layer_en_rd = NL'($urandom);
        layer_en_wr = NL'($urandom);
        dram_valid  = 1'($urandom);
        #1;
        exp_ctl = {m_ph != 0, m_ph == 3, m_ph == 4,
                   (m_ph == 1) ? (NL'(1) << m_k) : NL'(0), m_fl ? {NL{1'b1}} : NL'(0)};
        if (m_ph == 1 || m_ph == 2)
            exp_dram = {layer_addr_in[m_k*AW +: AW], layer_addr_out[m_k*AW +: AW],
                        layer_data_out[m_k*DW +: DW], layer_en_rd[m_k], layer_en_wr[m_k],
                        NL'(dram_valid) << m_k};
        else
            exp_dram = '0;
        if (chk_en) begin
            chk("ctl", {busy, done, err, layer_en, layer_flush}, exp_ctl);
            chk("err_layer", err_layer, 3'(m_errl));
            chk("total", total_cycles, m_tot);
            chk("dram", {addr_in, addr_out, data_out, dram_en_rd, dram_en_wr, layer_valid}, exp_dram);
        end
        s_busy = busy; s_done = done; s_err = err; s_en = layer_en;
        s_flush = layer_flush; s_total = total_cycles; s_el = err_layer;
        if (done === 1'b1) done_cnt++;
        @(posedge clk);
        model_step();
    endtask

    task automatic set_lat(input vec_t v);
        lat = '{v.l0, v.l1, v.l2, v.l3, v.l4};
        for (int i = 0; i < NL; i++) cnt[i] = -1;
        sp4 = v.sp;
        done_cnt = 0;
    endtask

    task automatic wait_en(input int k);
        int n = 0;
        while (s_en[k] !== 1'b1 && n < 2000) begin tick(); n++; end
        chk("wait_en", n < 2000, 1'b1);
    endtask

    task automatic run_case(input vec_t v);
        int n, dc, fc;
        set_lat(v);
        tick(1'b1);
        n = 0; dc = -1; fc = -1;
        do begin
            tick(); n++;
            if (s_done) dc = n;
        end while (s_busy && !s_err && n < 3000);
        if (!s_busy) fc = n;
        chk("tbl_bound", n < 3000, 1'b1);
        chk("tbl_total", s_total, v.tot);
        chk("tbl_ndone", done_cnt, v.nd);
        chk("tbl_err", s_err, v.e);
        chk("tbl_err_layer", s_el, v.el);
        if (v.nd == 1) chk("busy_fall", fc - dc, 1);
        if (s_err) begin
            tick(1'b1);
            tick();
            chk("err_exit_flush", {s_busy, s_flush}, {1'b0, {NL{1'b1}}});
            tick();
            chk("err_exit_flush_end", {s_busy, s_flush}, '0);
            tick(1'b1);
            tick();
            chk("relaunch_l0", {s_en, s_el}, {NL'(1), 3'd0});
            tick(1'b0, 1'b1);
            tick();
        end
        tick(); tick();
    endtask

    initial begin
        tbl[0] = '{10, 20, 30, 40, 50, 1'b0, 155, 1, 1'b0, 0};
        tbl[1] = '{10, 20, -1, 40, 50, 1'b0, 133, 0, 1'b1, 2};
        tbl[2] = '{1, 2, 3, 100, 4, 1'b1, 115, 1, 1'b0, 0};
        tbl[3] = '{1, 1, 1, 1, 1, 1'b0, 10, 1, 1'b0, 0};
        tbl[4] = '{101, 1, 1, 1, 1, 1'b0, 101, 0, 1'b1, 0};
        tbl[5] = '{5, 6, 7, 8, 99, 1'b0, 130, 1, 1'b0, 0};
        for (int i = 0; i < NL; i++) begin lat[i] = -1; cnt[i] = -1; end

        tick(0, 0, 1); tick(0, 0, 1);
        chk_en = 1'b1;
        tick();
        chk("rst_state", {s_busy, s_done, s_err, s_en, s_flush, s_el, s_total}, '0);

        for (int t = 0; t < 6; t++) run_case(tbl[t]);

        // Abort during RUN of layer 1
        set_lat(tbl[0]);
        tick(1'b1);
        wait_en(1);
        for (int i = 0; i < 5; i++) tick();
        tick(1'b0, 1'b1);
        tick();
        chk("abort_idle_flush", {s_busy, s_done, s_flush}, {2'b00, {NL{1'b1}}});
        chk("abort_partial_total", s_total, 18);
        tick();
        chk("abort_flush_end", s_flush, '0);
        chk("abort_no_done", done_cnt, 0);
        for (int i = 0; i < 60; i++) tick();

        // srst mid-run of layer 3
        set_lat(tbl[0]);
        tick(1'b1);
        wait_en(3);
        for (int i = 0; i < 3; i++) tick();
        tick(0, 0, 1);
        tick();
        chk("srst_state", {s_busy, s_done, s_err, s_en, s_flush, s_el, s_total}, '0);
        for (int i = 0; i < 60; i++) tick();

        // Start while busy
        set_lat(tbl[0]);
        tick(1'b1);
        wait_en(2);
        tick(1'b1); tick(); tick(1'b1);
        begin
            int n = 0;
            while (s_busy && n < 2000) begin tick(); n++; end
        end
        chk("busy_start_done", done_cnt, 1);
        chk("busy_start_total", s_total, 155);

        // Random traffic against the reference model
        rand_mode = 1'b1;
        sp4 = 1'b0;
        for (int t = 0; t < 4000; t++)
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 399) == 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
